// File: rtl/bpm_stream_pkg.sv
// Shared constants and encodings for the BPM AXI-Stream packet generator.
package bpm_stream_pkg;

  localparam logic [15:0] MAGIC     = 16'hA5BE;
  localparam logic [31:0] FAKE_CRC  = 32'hADADFACE;
  localparam int unsigned PKT_WORDS = 5;

  typedef enum logic [1:0] {
    MODE_RR     = 2'd0,
    MODE_SINGLE = 2'd1,
    MODE_BCAST  = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    W_HDR = 3'd0,
    W_X   = 3'd1,
    W_Y   = 3'd2,
    W_S   = 3'd3,
    W_CRC = 3'd4
  } word_idx_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/bpm_pkt_word_mux.sv
// Combinational packet word builder: selects HDR/X/Y/S/CRC content for the current word index.
module bpm_pkt_word_mux
  import bpm_stream_pkg::*;
(
  input  word_idx_e   word_idx_i,
  input  logic [8:0]  fofb_index_i,
  input  logic [15:0] seq_i,
  input  logic [4:0]  cell_index_i,
  output logic [31:0] word_o
);

  logic [31:0] x_word;

  assign x_word = {seq_i, 7'b0, fofb_index_i};

  always_comb begin
    word_o = FAKE_CRC;
    case (word_idx_i)
      W_HDR:   word_o = {MAGIC, 1'b1, cell_index_i, 1'b0, fofb_index_i};
      W_X:     word_o = x_word;
      W_Y:     word_o = ~x_word;
      W_S:     word_o = {2'b00, 21'b0, fofb_index_i};
      default: word_o = FAKE_CRC;
    endcase
  end

endmodule

// File: rtl/bpm_stream_generator.sv
// Emits bursts of fake BPM packets over NCHAN AXI-Stream channels on each FA strobe rising edge.
module bpm_stream_generator
  import bpm_stream_pkg::*;
#(
  parameter int unsigned NCHAN           = 2,
  parameter logic [4:0]  CELL_INDEX      = 5'd0,
  parameter logic [8:0]  FOFB_INDEX_INIT = 9'd0,
  parameter logic [8:0]  FOFB_INDEX_MAX  = 9'd7,
  parameter int unsigned GAP_CYCLES      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fa_strobe,
  input  logic [1:0]            mode,
  input  logic [1:0]            ch_sel,
  input  logic [NCHAN-1:0]      tready,
  output logic [32*NCHAN-1:0]   tdata,
  output logic [NCHAN-1:0]      tvalid,
  output logic [NCHAN-1:0]      tlast,
  output logic                  busy,
  output logic [7:0]            overrun_cnt
);

  localparam int unsigned    GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]  GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [1:0]     LAST_CH  = 2'(NCHAN - 1);
  localparam logic [2:0]     NCHAN_W  = 3'(NCHAN);
  localparam word_idx_e      W_LAST   = word_idx_e'(3'(PKT_WORDS - 1));

  state_e           state_q, state_d;
  logic             strobe_q, armed_q;
  logic [15:0]      seq_q, seq_d;
  logic [8:0]       fofb_q, fofb_d;
  word_idx_e        widx_q, widx_d;
  logic [1:0]       chan_q, chan_d;
  mode_e            mode_q, mode_d;
  logic [1:0]       sel_q, sel_d;
  logic [NCHAN-1:0] acc_q, acc_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [7:0]       ovr_q, ovr_d;

  logic             rise;
  logic [NCHAN-1:0] target;
  logic [NCHAN-1:0] fire;
  logic             done;
  logic [31:0]      word;

  bpm_pkt_word_mux u_word_mux (
    .word_idx_i   (widx_q),
    .fofb_index_i (fofb_q),
    .seq_i        (seq_q),
    .cell_index_i (CELL_INDEX),
    .word_o       (word)
  );

  // armed_q blocks a strobe that was already high when reset released
  assign rise = fa_strobe & ~strobe_q & armed_q;

  always_comb begin
    target = '0;
    if (state_q == ST_SEND) begin
      for (int unsigned c = 0; c < NCHAN; c++) begin
        case (mode_q)
          MODE_BCAST:  target[c] = 1'b1;
          MODE_SINGLE: target[c] = (sel_q == 2'(c));
          default:     target[c] = (chan_q == 2'(c));
        endcase
      end
    end
  end

  // Broadcast channels drop valid individually once accepted; the word completes when all have
  assign tvalid = target & ~acc_q;
  assign tlast  = tvalid & {NCHAN{widx_q == W_LAST}};
  assign fire   = tvalid & tready;
  assign done   = &(acc_q | fire | ~target);

  always_comb begin
    tdata = '0;
    for (int unsigned c = 0; c < NCHAN; c++) begin
      if (tvalid[c]) tdata[32*c +: 32] = word;
    end
  end

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    fofb_d  = fofb_q;
    widx_d  = widx_q;
    chan_d  = chan_q;
    mode_d  = mode_q;
    sel_d   = sel_q;
    acc_d   = acc_q;
    gap_d   = gap_q;
    ovr_d   = ovr_q;

    if (rise && (state_q != ST_IDLE) && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;

    case (state_q)
      ST_IDLE: begin
        if (rise && (mode_e'(mode) != MODE_OFF)) begin
          state_d = ST_SEND;
          seq_d   = seq_q + 16'd1;
          fofb_d  = FOFB_INDEX_INIT;
          widx_d  = W_HDR;
          chan_d  = '0;
          mode_d  = mode_e'(mode);
          sel_d   = ({1'b0, ch_sel} < NCHAN_W) ? ch_sel : 2'd0;
          acc_d   = '0;
        end
      end
      ST_SEND: begin
        acc_d = acc_q | fire;
        if (done) begin
          acc_d = '0;
          if ((widx_q == W_LAST) && (fofb_q == FOFB_INDEX_MAX)) begin
            state_d = ST_IDLE;
          end else begin
            if (widx_q == W_LAST) begin
              fofb_d = fofb_q + 9'd1;
              widx_d = W_HDR;
              chan_d = (chan_q == LAST_CH) ? 2'd0 : chan_q + 2'd1;
            end else begin
              widx_d = word_idx_e'(widx_q + 3'd1);
            end
            if (GAP_CYCLES != 0) begin
              state_d = ST_GAP;
              gap_d   = GAP_LOAD;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_SEND;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      strobe_q <= 1'b0;
      armed_q  <= 1'b0;
      seq_q    <= '0;
      fofb_q   <= '0;
      widx_q   <= W_HDR;
      chan_q   <= '0;
      mode_q   <= MODE_RR;
      sel_q    <= '0;
      acc_q    <= '0;
      gap_q    <= '0;
      ovr_q    <= '0;
    end else begin
      state_q  <= state_d;
      strobe_q <= fa_strobe;
      armed_q  <= armed_q | ~fa_strobe;
      seq_q    <= seq_d;
      fofb_q   <= fofb_d;
      widx_q   <= widx_d;
      chan_q   <= chan_d;
      mode_q   <= mode_d;
      sel_q    <= sel_d;
      acc_q    <= acc_d;
      gap_q    <= gap_d;
      ovr_q    <= ovr_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign overrun_cnt = ovr_q;

endmodule

// File: doc/bpm_stream_generator.md
BPM_STREAM_GENERATOR -- requirements
Module: bpm_stream_generator

Interface
REQ-001 Parameter NCHAN, default 2: number of AXI-Stream output channels, legal range 1..4.
REQ-002 Parameter CELL_INDEX, default 0: 5-bit cell index placed in every header.
REQ-003 Parameter FOFB_INDEX_INIT, default 0: 9-bit first FOFB index of each burst.
REQ-004 Parameter FOFB_INDEX_MAX, default 7: 9-bit last FOFB index of each burst (inclusive), >= FOFB_INDEX_INIT.
REQ-005 Parameter GAP_CYCLES, default 1: idle cycles (tvalid low) after each accepted word; 0 means back-to-back words.
REQ-006 Port clk, input, 1: single clock; one clock, reset is asynchronous and active-low.
REQ-007 Port rst_n, input, 1: asynchronous active-low reset.
REQ-008 Port fa_strobe, input, 1: FA trigger; a burst starts on its rising edge.
REQ-009 Port mode, input, 2: 0 = round-robin, 1 = single channel, 2 = broadcast, 3 = disabled; sampled at burst start.
REQ-010 Port ch_sel, input, 2: target channel for mode 1, sampled at burst start; values >= NCHAN select channel 0.
REQ-011 Port tready, input, NCHAN: per-channel downstream ready.
REQ-012 Port tdata, output, 32*NCHAN: channel c occupies bits [32c+31:32c].
REQ-013 Port tvalid / tlast, output, NCHAN each: per-channel valid and last-word flags.
REQ-014 Port busy, output, 1: high from burst start until the last CRC word is accepted.
REQ-015 Port overrun_cnt, output, 8: saturating count of strobe edges ignored while busy.

Function
REQ-016 Packet is 5 words in order HDR, X, Y, S, CRC.
REQ-017 HDR = {16'hA5BE, 1'b1, CELL_INDEX[4:0], 1'b0, fofb_index[8:0]}.
REQ-018 X = {seq[15:0], 7'b0, fofb_index}; Y = bitwise NOT of X; S = {2'b00, 21'b0, fofb_index}; CRC = 32'hADADFACE.
REQ-019 seq: 16-bit burst counter, 0 after reset, incremented at each burst start, wraps FFFF->0000; the first burst uses seq 1.
REQ-020 FSM states: IDLE, SEND, GAP. IDLE->SEND on a fa_strobe rising edge (edge detected against the previous-cycle register) with mode != 3; a rising edge with mode 3 is ignored and leaves the FSM in IDLE.
REQ-021 The first tvalid rises one cycle after the clk edge that samples the strobe edge.
REQ-022 Each burst emits FOFB_INDEX_MAX-FOFB_INDEX_INIT+1 packets with fofb_index incrementing from FOFB_INDEX_INIT.
REQ-023 Round-robin: packet k of a burst goes to channel k mod NCHAN, restarting at channel 0 every burst.
REQ-024 Single mode: all packets go to ch_sel. Broadcast: every packet goes to all NCHAN channels.
REQ-025 Handshake: tvalid stays high and tdata/tlast stay stable until tready; tvalid never depends combinationally on tready.
REQ-026 Broadcast: each channel drops tvalid once it has accepted the current word; the word advances only after all channels accept, which tolerates skewed tready.
REQ-027 After a word completes, the FSM enters GAP for GAP_CYCLES cycles, or goes directly to the next word if GAP_CYCLES = 0.
REQ-028 tlast is high only with the CRC word; acceptance of the final CRC word returns the FSM to IDLE and deasserts busy the same cycle.
REQ-029 A strobe rising edge while busy is ignored and increments overrun_cnt, which saturates at 255.
REQ-030 Channels not targeted by the current packet hold tvalid = 0, tlast = 0 and tdata = 0.

Reset
REQ-031 rst_n low asynchronously forces IDLE; all tvalid, tlast, tdata, busy, overrun_cnt, seq and the strobe edge register go to 0, including in mid-packet.
REQ-032 After rst_n deasserts, a strobe that is already high produces no burst until it falls and rises again.

Structure
REQ-033 Shared package bpm_stream_pkg holds MAGIC, FAKE_CRC, PKT_WORDS = 5, the mode encodings and the word-index enum.
REQ-034 Sub-module bpm_pkt_word_mux (combinational) builds the 32-bit word from word index, fofb_index, seq and CELL_INDEX.

Verification
REQ-035 CELL_INDEX = 3, mode 0, NCHAN = 2, tready all 1, GAP_CYCLES = 1, one strobe -> 8 packets alternating ch0/ch1; first HDR 0xA5BE8C00, ch1's first HDR 0xA5BE8C01, each packet ends with tlast on 0xADADFACE.
REQ-036 Mode 2, tready[1] held low for 10 cycles after the first word -> ch0 accepts and waits; the word advances only after ch1 accepts; both channels receive identical 40-word streams.
REQ-037 Mode 1, ch_sel = 1, GAP_CYCLES = 0 -> 40 consecutive tvalid cycles on ch1, ch0 silent, busy high exactly 40 cycles.
REQ-038 Second strobe edge during a burst -> burst unaffected, overrun_cnt = 1; 300 such edges -> overrun_cnt = 255.
REQ-039 rst_n pulsed low during the Y word of packet 3 -> all outputs 0 immediately; the next strobe starts a fresh burst at FOFB_INDEX_INIT with X[31:16] = 0x0001.
REQ-040 Mode 3 strobe -> no tvalid, busy stays 0, seq unchanged.
